// File: rtl/multicycle_control_fsm_if.sv
// Handshake/bus bundle between the multi-cycle sequencer and its decoder, ALU and memories.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface multicycle_control_fsm_if #(
  parameter int unsigned XLEN = 32
) ();
  logic [6:0]      opcode;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_result;
  logic            branch_taken;
  logic            ifetch_ack;
  logic            dmem_ack;

  logic [XLEN-1:0] pc;
  logic            ifetch_req;
  logic            ir_load;
  logic            dmem_req;
  logic            dmem_we;
  logic            rf_we;
  logic [1:0]      wb_sel;
  logic            instr_retired;
  logic            illegal_instr;
  logic            mem_fault;
  logic [2:0]      state;

  modport master (
    input  opcode, imm, alu_result, branch_taken, ifetch_ack, dmem_ack,
    output pc, ifetch_req, ir_load, dmem_req, dmem_we, rf_we, wb_sel,
           instr_retired, illegal_instr, mem_fault, state
  );

  modport slave (
    output opcode, imm, alu_result, branch_taken, ifetch_ack, dmem_ack,
    input  pc, ifetch_req, ir_load, dmem_req, dmem_we, rf_we, wb_sel,
           instr_retired, illegal_instr, mem_fault, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencer: owns the PC, runs the FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP
// state machine, drives memory request handshakes with a timeout and gates register writes.
module multicycle_control_fsm #(
  parameter int unsigned           XLEN        = 32,
  parameter logic [XLEN-1:0]       RESET_PC    = '0,
  parameter int unsigned           MEM_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_control_fsm_if.master bus
);

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // The wait counter holds the number of unacked cycles so far; the last allowed
  // unacked cycle is the one where it would reach MEM_TIMEOUT.
  localparam logic [7:0] CNT_LAST  = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [7:0]      r_cnt;
  logic [6:0]      r_op;
  logic            r_retire;
  logic            r_illegal;
  logic            r_fault;

  state_t          w_state_next;
  logic [XLEN-1:0] w_pc_next;
  logic [7:0]      w_cnt_next;
  logic [6:0]      w_op_next;
  logic            w_retire_next;
  logic            w_illegal_next;
  logic            w_fault_next;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_plus_imm;
  logic [XLEN-1:0] w_jalr_target;
  logic            w_timeout;
  logic [1:0]      w_wb_sel;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  assign w_pc_plus4    = r_pc + XLEN'(4);
  assign w_pc_plus_imm = r_pc + bus.imm;
  assign w_jalr_target = {bus.alu_result[XLEN-1:1], 1'b0};
  assign w_timeout     = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_cnt     <= 8'd0;
      r_op      <= 7'd0;
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_cnt     <= w_cnt_next;
      r_op      <= w_op_next;
      r_retire  <= w_retire_next;
      r_illegal <= w_illegal_next;
      r_fault   <= w_fault_next;
    end
  end

  // The opcode is captured in DECODE so every later output depends only on registers.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_cnt_next     = r_cnt;
    w_op_next      = r_op;
    w_retire_next  = 1'b0;
    w_illegal_next = r_illegal;
    w_fault_next   = r_fault;
    case (r_state)
      S_FETCH: begin
        if (bus.ifetch_ack) begin
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
          w_fault_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        w_op_next = bus.opcode;
        if (is_legal(bus.opcode)) begin
          w_state_next = S_EXECUTE;
        end else begin
          w_state_next   = S_TRAP;
          w_illegal_next = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (r_op == OP_BRANCH) begin
          w_pc_next     = bus.branch_taken ? w_pc_plus_imm : w_pc_plus4;
          w_retire_next = 1'b1;
          w_cnt_next    = 8'd0;
          w_state_next  = S_FETCH;
        end else if (r_op == OP_LOAD || r_op == OP_STORE) begin
          w_cnt_next   = 8'd0;
          w_state_next = S_MEM;
        end else begin
          w_retire_next = 1'b1;
          w_state_next  = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          w_retire_next = 1'b1;
          if (r_op == OP_STORE) begin
            w_pc_next    = w_pc_plus4;
            w_cnt_next   = 8'd0;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_state_next = S_TRAP;
          w_fault_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_WRITEBACK: begin
        if (r_op == OP_JAL) begin
          w_pc_next = w_pc_plus_imm;
        end else if (r_op == OP_JALR) begin
          w_pc_next = w_jalr_target;
        end else begin
          w_pc_next = w_pc_plus4;
        end
        w_cnt_next   = 8'd0;
        w_state_next = S_FETCH;
      end
      S_TRAP: begin
        w_state_next = S_TRAP;
      end
      default: begin
        w_state_next = S_TRAP;
      end
    endcase
  end

  always_comb begin
    w_wb_sel = 2'd0;
    if (r_state == S_WRITEBACK) begin
      if (r_op == OP_LOAD) begin
        w_wb_sel = 2'd1;
      end else if (r_op == OP_JAL || r_op == OP_JALR) begin
        w_wb_sel = 2'd2;
      end
    end
  end

  assign bus.pc            = r_pc;
  assign bus.ifetch_req    = (r_state == S_FETCH);
  assign bus.ir_load       = (r_state == S_FETCH) && bus.ifetch_ack;
  assign bus.dmem_req      = (r_state == S_MEM);
  assign bus.dmem_we       = (r_state == S_MEM) && (r_op == OP_STORE);
  assign bus.rf_we         = (r_state == S_WRITEBACK);
  assign bus.wb_sel        = w_wb_sel;
  assign bus.instr_retired = r_retire;
  assign bus.illegal_instr = r_illegal;
  assign bus.mem_fault     = r_fault;
  assign bus.state         = r_state;

endmodule
